muldiv_iter: RTL and testbench
==============================

// Module: muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit; multi-cycle successor to the 32-bit
//  single-cycle arithmetic unit's hi/lo path. Shift-add multiply, restoring divide,
//  one bit per cycle, start/busy/done handshake. Sits beside the ALU; hi/lo feed HI/LO regs.
// PARAMETERS
//  W  32  operand width; hi/lo are W bits each, product is 2W bits (W >= 4)
// PORTS
//  clk     in   1  clock, all state updates on rising edge
//  rst_n   in   1  synchronous, active-low reset
//  start   in   1  request; sampled only when busy=0
//  op      in   2  2'b10 multiply, 2'b11 divide; 2'b00/2'b01 illegal, start ignored
//  sgn     in   1  signed operands (used only with MULDIV_SIGNED_EN; else ignored)
//  a       in   W  multiplicand / dividend, captured on accepted start
//  b       in   W  multiplier / divisor, captured on accepted start
//  busy    out  1  operation in progress
//  done    out  1  one-cycle pulse; hi/lo/zero/dz valid from this cycle
//  hi      out  W  mul: upper W product bits; div: remainder
//  lo      out  W  mul: lower W product bits; div: quotient
//  zero    out  1  hi==0 && lo==0, registered with result
//  dz      out  1  divide-by-zero flag, registered with result
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; busy=0, done=0, hi=0, lo=0, zero=1, dz=0.
//  - FSM: IDLE -> RUN (accepted start) -> FINISH (after W iterations) -> IDLE.
//  - Accept: edge k with start=1, busy=0, op[1]=1; a,b,op,sgn latched; busy=1 from k+1.
//  - RUN: edges k+1..k+W each perform one iteration; 6-bit-wide-enough counter (clog2(W+1)).
//  - FINISH: edge k+W+1 registers hi/lo/zero/dz, done=1 for exactly that cycle, busy=0.
//  - Latency fixed W+1 cycles start->done for all ops incl. divide-by-zero.
//  - start while busy=1: ignored, no queueing, latched operands unchanged.
//  - start in the done cycle: accepted (back-to-back; busy=1 next cycle).
//  - hi/lo/zero/dz hold last result until next done or reset; not disturbed during RUN.
//  - Multiply: {hi,lo} = a*b exact, 2W bits, no overflow possible.
//  - Divide: a = lo*b + hi, 0 <= hi < b (unsigned).
//  - b==0 divide: lo = all ones, hi = a, dz=1. dz=0 for every multiply and b!=0 divide.
//  - Reset mid-operation: abort, return to IDLE with reset values; no done pulse.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined: sgn=1 selects two's-complement operation.
//   - operands converted to magnitude at accept, result sign-corrected in FINISH (latency unchanged).
//   - mul: signed 2W product. div: quotient truncates toward zero, remainder takes dividend sign.
//   - MIN / -1: lo = MIN, hi = 0, dz=0. b==0: lo = all ones, hi = a, dz=1.
//  MULDIV_SIGNED_EN undefined: sgn ignored, all ops unsigned; no sign logic synthesised.
// TESTING (W=32)
//  - mul 7*3, start at edge 0 -> busy edges 1..32, done at edge 33, hi=0, lo=21, zero=0.
//  - mul 5000000*45000000 -> hi=32'h0000CCA2, lo=32'hE5131000; mul 0*1 -> hi=lo=0, zero=1.
//  - div 7/3 -> hi=1, lo=2; div 59/8 -> hi=3, lo=7; dz=0 both.
//  - div 5/0 -> hi=5, lo=32'hFFFFFFFF, dz=1, done still at start+33.
//  - start 9*9 at edge 0, start 2*2 at edge 5 (busy) -> ignored, lo=81; start 2*2 in done cycle -> lo=4 exactly 33 cycles later.
//  - rst_n=0 at edge 10 of a divide -> no done, hi=lo=0, zero=1, busy=0; signed build: -7/2 sgn=1 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, start/busy/done handshake.
// Optional two's-complement mode is enabled by defining MULDIV_SIGNED_EN.
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         zero,
  output logic         dz
);

  // state    | meaning
  // S_IDLE   | waiting for an accepted start
  // S_RUN    | W single-bit iterations, counted down by cnt
  // S_FINISH | one cycle before results are registered and done pulses
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam int CW = $clog2(W + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic          bz;
  logic [W-1:0]  opnd;
  logic [W-1:0]  acc;
  logic [W-1:0]  sh;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;

  logic [W:0]    sum;
  logic [W:0]    rs;
  logic          ge;
  logic [W-1:0]  diff;
  logic [W-1:0]  acc_n;
  logic [W-1:0]  sh_n;
  logic [W-1:0]  fin_hi;
  logic [W-1:0]  fin_lo;

`ifdef MULDIV_SIGNED_EN
  logic           sa;
  logic           sb;
  logic           neg_q;
  logic           neg_r;
  logic [2*W-1:0] prod_neg;

  assign sa    = sgn & a[W-1];
  assign sb    = sgn & b[W-1];
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign a_mag      = a;
  assign b_mag      = b;
`endif

  // acc/sh hold {product hi, multiplier/product lo} or {remainder, dividend/quotient}
  always_comb begin
    sum  = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    rs   = {acc, sh[W-1]};
    ge   = (rs >= {1'b0, opnd});
    diff = rs[W-1:0] - opnd;
    if (is_div) begin
      acc_n = ge ? diff : rs[W-1:0];
      sh_n  = {sh[W-2:0], ge};
    end else begin
      acc_n = sum[W:1];
      sh_n  = {sum[0], sh[W-1:1]};
    end
  end

  always_comb begin
    fin_hi = acc;
    fin_lo = sh;
`ifdef MULDIV_SIGNED_EN
    prod_neg = -{acc, sh};
    if (!is_div) begin
      if (neg_q) begin
        fin_hi = prod_neg[2*W-1:W];
        fin_lo = prod_neg[W-1:0];
      end
    end else begin
      // b==0 keeps the all-ones quotient; remainder negation restores the original dividend
      if (neg_q && !bz) fin_lo = -sh;
      if (neg_r)        fin_hi = -acc;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      bz     <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      sh     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      zero   <= 1'b1;
      dz     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && op[1]) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            cnt    <= CW'(W);
            is_div <= op[0];
            bz     <= (b == '0);
            opnd   <= op[0] ? b_mag : a_mag;
            sh     <= op[0] ? a_mag : b_mag;
            acc    <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
`endif
          end
        end
        S_RUN: begin
          acc <= acc_n;
          sh  <= sh_n;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FINISH;
        end
        S_FINISH: begin
          hi    <= fin_hi;
          lo    <= fin_lo;
          zero  <= (fin_hi == '0) && (fin_lo == '0);
          dz    <= is_div && bz;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized self-checking bench for muldiv_iter (W=32) against an arithmetic reference model.
module tb_muldiv_iter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         zero;
  logic         dz;

  int total = 0;
  int bad   = 0;

  muldiv_iter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sgn(sgn),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .zero(zero), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic s, output logic [31:0] h, output logic [31:0] l,
                                output logic d);
    logic [63:0] p;
    longint sx, sy, q, r;
    logic sm;
    sm = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sm = s;
`endif
    sx = $signed(x);
    sy = $signed(y);
    d  = 1'b0;
    if (o == 2'b10) begin
      if (sm) begin
        q = sx * sy;
        p = q;
      end else begin
        p = 64'(x) * 64'(y);
      end
      h = p[63:32];
      l = p[31:0];
    end else if (y == 0) begin
      l = 32'hFFFF_FFFF;
      h = x;
      d = 1'b1;
    end else if (sm) begin
      q = sx / sy;
      r = sx % sy;
      l = q[31:0];
      h = r[31:0];
    end else begin
      l = x / y;
      h = x % y;
    end
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; sgn = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    total += 6;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    if (hi !== '0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    if (lo !== '0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", zero); end
    if (dz !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", dz); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic s);
    logic [31:0] eh, el;
    logic ed;
    int n;
    model(o, x, y, s, eh, el, ed);
    issue(o, x, y, s);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b want=1", name, busy); end
    wait_done(n);
    total += 6;
    if (n != W + 1) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, n, W + 1); end
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done got=%b want=0", name, busy); end
    if (hi !== eh) begin bad++; $display("FAIL %s hi got=%h want=%h (a=%h b=%h)", name, hi, eh, x, y); end
    if (lo !== el) begin bad++; $display("FAIL %s lo got=%h want=%h (a=%h b=%h)", name, lo, el, x, y); end
    if (zero !== (eh == 0 && el == 0)) begin bad++; $display("FAIL %s zero got=%b want=%b", name, zero, (eh == 0 && el == 0)); end
    if (dz !== ed) begin bad++; $display("FAIL %s dz got=%b want=%b", name, dz, ed); end
  endtask

  task automatic test_directed;
    run_check("mul_7x3",    2'b10, 32'd7,       32'd3,        1'b0);
    run_check("mul_big",    2'b10, 32'd5000000, 32'd45000000, 1'b0);
    total += 2;
    if (hi !== 32'h0000CCA2) begin bad++; $display("FAIL mul_big_const hi got=%h want=0000cca2", hi); end
    if (lo !== 32'hE5131000) begin bad++; $display("FAIL mul_big_const lo got=%h want=e5131000", lo); end
    run_check("mul_0x1",    2'b10, 32'd0,       32'd1,        1'b0);
    run_check("div_7_3",    2'b11, 32'd7,       32'd3,        1'b0);
    run_check("div_59_8",   2'b11, 32'd59,      32'd8,        1'b0);
    run_check("div_5_0",    2'b11, 32'd5,       32'd0,        1'b0);
    run_check("mul_max",    2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_check("div_max_1",  2'b11, 32'hFFFFFFFF, 32'd1,       1'b0);
    run_check("div_small",  2'b11, 32'd3,       32'hFFFFFFFF, 1'b0);
  endtask

  task automatic test_random;
    logic [1:0] o;
    logic [31:0] x, y;
    logic s;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(2, 3));
      x = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: y = '0;
        1: y = 32'($urandom_range(1, 255));
        default: y = $urandom;
      endcase
      run_check("random", o, x, y, s);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ph, pl;
    ph = hi; pl = lo;
    for (int k = 0; k < 2; k++) begin
      issue(2'(k), 32'd6, 32'd7, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      total += 3;
      if (busy !== 1'b0) begin bad++; $display("FAIL illegal_op%0d busy got=%b want=0", k, busy); end
      if (hi !== ph) begin bad++; $display("FAIL illegal_op%0d hi got=%h want=%h", k, hi, ph); end
      if (lo !== pl) begin bad++; $display("FAIL illegal_op%0d lo got=%h want=%h", k, lo, pl); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ph, pl;
    int n;
    ph = hi; pl = lo;
    issue(2'b10, 32'd9, 32'd9, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd2; b = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    total += 3;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_ignore busy got=%b want=1", busy); end
    if (hi !== ph) begin bad++; $display("FAIL hold_during_run hi got=%h want=%h", hi, ph); end
    if (lo !== pl) begin bad++; $display("FAIL hold_during_run lo got=%h want=%h", lo, pl); end
    wait_done(n);
    total += 2;
    if (n + 5 != W + 1) begin bad++; $display("FAIL busy_ignore latency got=%0d want=%0d", n + 5, W + 1); end
    if (lo !== 32'd81) begin bad++; $display("FAIL busy_ignore lo got=%0d want=81", lo); end
    issue(2'b10, 32'd2, 32'd2, 1'b0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b busy got=%b want=1", busy); end
    wait_done(n);
    total += 2;
    if (n != W + 1) begin bad++; $display("FAIL b2b latency got=%0d want=%0d", n, W + 1); end
    if (lo !== 32'd4) begin bad++; $display("FAIL b2b lo got=%0d want=4", lo); end
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_mid done got=%b want=0", done); end
    if (hi !== '0) begin bad++; $display("FAIL rst_mid hi got=%h want=0", hi); end
    if (lo !== '0) begin bad++; $display("FAIL rst_mid lo got=%h want=0", lo); end
    if (zero !== 1'b1) begin bad++; $display("FAIL rst_mid zero got=%b want=1", zero); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rst_mid activity got=%0d want=0", seen); end
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed;
    run_check("sdiv_m7_2",   2'b11, 32'hFFFFFFF9, 32'd2,        1'b1);
    total += 2;
    if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL sdiv_const lo got=%h want=fffffffd", lo); end
    if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL sdiv_const hi got=%h want=ffffffff", hi); end
    run_check("sdiv_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    run_check("sdiv_m5_0",   2'b11, 32'hFFFFFFFB, 32'd0,        1'b1);
    run_check("smul_m3_7",   2'b10, 32'hFFFFFFFD, 32'd7,        1'b1);
    run_check("smul_min",    2'b10, 32'h80000000, 32'h80000000, 1'b1);
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_illegal;
    test_back_to_back;
    test_random;
`ifdef MULDIV_SIGNED_EN
    test_signed;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
